// File: rtl/mem_pkg.sv
// Shared types for the memory-access stage: access sizes, FSM states,
// the memory-to-writeback record and the data-bus request bundle.
package mem_pkg;

  localparam int MEM_ADDR_W = 64;
  localparam int MEM_DATA_W = 64;
  localparam int MEM_STRB_W = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    MSIZE_B = 2'd0,
    MSIZE_H = 2'd1,
    MSIZE_W = 2'd2,
    MSIZE_D = 2'd3
  } msize_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] pc;
    logic [MEM_ADDR_W-1:0] result;
    logic                  memread;
    msize_t                msize;
    logic                  mem_unsigned;
    logic                  regwrite;
    logic [4:0]            writereg;
  } mem_record_t;

  typedef struct packed {
    logic [MEM_ADDR_W-1:0] addr;
    logic                  write;
    logic [MEM_STRB_W-1:0] strobe;
    logic [MEM_DATA_W-1:0] wdata;
  } dbus_req_t;

  // Natural alignment check: the access must not straddle its own size.
  function automatic logic is_misaligned(input msize_t sz, input logic [2:0] a);
    logic mis;
    case (sz)
      MSIZE_B: mis = 1'b0;
      MSIZE_H: mis = a[0];
      MSIZE_W: mis = |a[1:0];
      MSIZE_D: mis = |a[2:0];
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store lane steering: byte enables, replicated store data
// and the misalignment flag for one access.
module store_align
  import mem_pkg::*;
(
  input  msize_t      msize,
  input  logic [2:0]  addr_lo,
  input  logic [63:0] wdata,
  output logic [7:0]  strobe,
  output logic [63:0] wdata_lane,
  output logic        misalign
);

  // Replicate the low bytes across the bus so any lane the strobe picks holds the data.
  always_comb begin
    strobe     = 8'h00;
    wdata_lane = 64'd0;
    case (msize)
      MSIZE_B: begin
        strobe     = 8'h01 << addr_lo;
        wdata_lane = {8{wdata[7:0]}};
      end
      MSIZE_H: begin
        strobe     = 8'h03 << addr_lo;
        wdata_lane = {4{wdata[15:0]}};
      end
      MSIZE_W: begin
        strobe     = 8'h0F << addr_lo;
        wdata_lane = {2{wdata[31:0]}};
      end
      MSIZE_D: begin
        strobe     = 8'hFF;
        wdata_lane = wdata;
      end
      default: begin
        strobe     = 8'h00;
        wdata_lane = 64'd0;
      end
    endcase
  end

  assign misalign = is_misaligned(msize, addr_lo);

endmodule

// File: rtl/mem_access.sv
// Memory stage: passes non-memory ops straight to writeback and runs one
// request/response data-bus transaction for each aligned load or store.
module mem_access
  import mem_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ADDR_W-1:0]   in_pc,
  input  logic [ADDR_W-1:0]   in_result,
  input  logic [DATA_W-1:0]   in_wdata,
  input  logic                in_memread,
  input  logic                in_memwrite,
  input  logic [1:0]          in_msize,
  input  logic                in_mem_unsigned,
  input  logic                in_regwrite,
  input  logic [4:0]          in_writereg,
  output logic                dreq_valid,
  input  logic                dreq_ready,
  output logic [ADDR_W-1:0]   dreq_addr,
  output logic                dreq_write,
  output logic [DATA_W/8-1:0] dreq_strobe,
  output logic [DATA_W-1:0]   dreq_wdata,
  input  logic                dresp_valid,
  input  logic [DATA_W-1:0]   dresp_data,
  output logic                out_valid,
  output logic [ADDR_W-1:0]   out_pc,
  output logic [ADDR_W-1:0]   out_result,
  output logic [DATA_W-1:0]   out_rdata,
  output logic                out_memread,
  output logic [1:0]          out_msize,
  output logic                out_mem_unsigned,
  output logic                out_regwrite,
  output logic [4:0]          out_writereg,
  output logic                out_misalign
);

  mem_state_t  state_r;
  mem_state_t  state_nx_s;
  mem_record_t rec_r;
  dbus_req_t   req_r;

  logic [7:0]  strobe_s;
  logic [63:0] wdata_lane_s;
  logic        misalign_s;
  logic        mem_op_s;
  logic        accept_s;
  logic        direct_s;
  logic        issue_s;
  logic        resp_done_s;

  store_align u_store_align (
    .msize      (msize_t'(in_msize)),
    .addr_lo    (in_result[2:0]),
    .wdata      (in_wdata),
    .strobe     (strobe_s),
    .wdata_lane (wdata_lane_s),
    .misalign   (misalign_s)
  );

  assign in_ready    = (state_r == ST_IDLE);
  assign mem_op_s    = in_memread || in_memwrite;
  assign accept_s    = in_valid && in_ready && !flush;
  assign direct_s    = accept_s && (!mem_op_s || misalign_s);
  assign issue_s     = accept_s && mem_op_s && !misalign_s;
  // A flush withdraws an un-handshaken request in the same cycle.
  assign dreq_valid  = (state_r == ST_REQ) && !flush;
  assign resp_done_s = (state_r == ST_WAIT) && dresp_valid && !flush;

  assign dreq_addr   = req_r.addr;
  assign dreq_write  = req_r.write;
  assign dreq_strobe = req_r.strobe;
  assign dreq_wdata  = req_r.wdata;

  // Transaction FSM next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (issue_s) state_nx_s = ST_REQ;
        else         state_nx_s = ST_IDLE;
      end
      ST_REQ: begin
        if (flush)           state_nx_s = ST_IDLE;
        else if (dreq_ready) state_nx_s = ST_WAIT;
        else                 state_nx_s = ST_REQ;
      end
      ST_WAIT: begin
        if (dresp_valid) state_nx_s = ST_IDLE;
        else if (flush)  state_nx_s = ST_DRAIN;
        else             state_nx_s = ST_WAIT;
      end
      ST_DRAIN: begin
        if (dresp_valid) state_nx_s = ST_IDLE;
        else             state_nx_s = ST_DRAIN;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register plus the latched record and bus request of the op in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      rec_r   <= '0;
      req_r   <= '0;
    end else begin
      state_r <= state_nx_s;
      if (issue_s) begin
        rec_r.pc           <= in_pc;
        rec_r.result       <= in_result;
        rec_r.memread      <= in_memread;
        rec_r.msize        <= msize_t'(in_msize);
        rec_r.mem_unsigned <= in_mem_unsigned;
        rec_r.regwrite     <= in_regwrite;
        rec_r.writereg     <= in_writereg;
        req_r.addr         <= {in_result[ADDR_W-1:3], 3'b000};
        req_r.write        <= in_memwrite;
        req_r.strobe       <= in_memwrite ? strobe_s : 8'h00;
        req_r.wdata        <= wdata_lane_s;
      end
    end
  end

  // Writeback record: single-cycle out_valid, fields refreshed only when a record retires.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid        <= 1'b0;
      out_pc           <= 64'd0;
      out_result       <= 64'd0;
      out_rdata        <= 64'd0;
      out_memread      <= 1'b0;
      out_msize        <= 2'd0;
      out_mem_unsigned <= 1'b0;
      out_regwrite     <= 1'b0;
      out_writereg     <= 5'd0;
      out_misalign     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (direct_s) begin
        out_valid        <= 1'b1;
        out_pc           <= in_pc;
        out_result       <= in_result;
        out_rdata        <= 64'd0;
        out_memread      <= in_memread;
        out_msize        <= in_msize;
        out_mem_unsigned <= in_mem_unsigned;
        out_regwrite     <= in_regwrite && !(mem_op_s && misalign_s);
        out_writereg     <= in_writereg;
        out_misalign     <= mem_op_s && misalign_s;
      end else if (resp_done_s) begin
        out_valid        <= 1'b1;
        out_pc           <= rec_r.pc;
        out_result       <= rec_r.result;
        out_rdata        <= rec_r.memread ? dresp_data : 64'd0;
        out_memread      <= rec_r.memread;
        out_msize        <= rec_r.msize;
        out_mem_unsigned <= rec_r.mem_unsigned;
        out_regwrite     <= rec_r.regwrite;
        out_writereg     <= rec_r.writereg;
        out_misalign     <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: expected writeback records go into a
// scoreboard queue as stimulus is driven and are popped when out_valid fires.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [63:0] in_result;
  logic [63:0] in_wdata;
  logic        in_memread;
  logic        in_memwrite;
  logic [1:0]  in_msize;
  logic        in_mem_unsigned;
  logic        in_regwrite;
  logic [4:0]  in_writereg;
  logic        dreq_valid;
  logic        dreq_ready;
  logic [63:0] dreq_addr;
  logic        dreq_write;
  logic [7:0]  dreq_strobe;
  logic [63:0] dreq_wdata;
  logic        dresp_valid;
  logic [63:0] dresp_data;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [63:0] out_result;
  logic [63:0] out_rdata;
  logic        out_memread;
  logic [1:0]  out_msize;
  logic        out_mem_unsigned;
  logic        out_regwrite;
  logic [4:0]  out_writereg;
  logic        out_misalign;

  typedef logic [202:0] rec_v_t;

  rec_v_t exp_q[$];
  int     checks = 0;
  int     failures = 0;
  int     out_pulses = 0;

  always #5 clk = ~clk;

  mem_access dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_result(in_result), .in_wdata(in_wdata), .in_memread(in_memread),
    .in_memwrite(in_memwrite), .in_msize(in_msize),
    .in_mem_unsigned(in_mem_unsigned), .in_regwrite(in_regwrite),
    .in_writereg(in_writereg),
    .dreq_valid(dreq_valid), .dreq_ready(dreq_ready), .dreq_addr(dreq_addr),
    .dreq_write(dreq_write), .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
    .dresp_valid(dresp_valid), .dresp_data(dresp_data),
    .out_valid(out_valid), .out_pc(out_pc), .out_result(out_result),
    .out_rdata(out_rdata), .out_memread(out_memread), .out_msize(out_msize),
    .out_mem_unsigned(out_mem_unsigned), .out_regwrite(out_regwrite),
    .out_writereg(out_writereg), .out_misalign(out_misalign)
  );

  always @(negedge clk) if (out_valid === 1'b1) out_pulses++;

  function automatic rec_v_t mk_exp(input logic [63:0] pc, input logic [63:0] res,
                                    input logic [63:0] rdata, input logic [4:0] wr,
                                    input logic rw, input logic mis, input logic mr,
                                    input logic [1:0] ms, input logic mu);
    return {pc, res, rdata, wr, rw, mis, mr, ms, mu};
  endfunction

  function automatic rec_v_t dut_rec();
    return {out_pc, out_result, out_rdata, out_writereg, out_regwrite,
            out_misalign, out_memread, out_msize, out_mem_unsigned};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; in_pc = 64'd0; in_result = 64'd0;
    in_wdata = 64'd0; in_memread = 1'b0; in_memwrite = 1'b0; in_msize = 2'd0;
    in_mem_unsigned = 1'b0; in_regwrite = 1'b0; in_writereg = 5'd0;
    dreq_ready = 1'b0; dresp_valid = 1'b0; dresp_data = 64'd0;
  endtask

  task automatic drive_op(input logic [63:0] pc, input logic [63:0] res,
                          input logic [63:0] wd, input logic mr, input logic mw,
                          input logic [1:0] ms, input logic mu, input logic rw,
                          input logic [4:0] wr);
    in_valid = 1'b1; in_pc = pc; in_result = res; in_wdata = wd;
    in_memread = mr; in_memwrite = mw; in_msize = ms; in_mem_unsigned = mu;
    in_regwrite = rw; in_writereg = wr;
  endtask

  task automatic test_reset();
    idle_inputs();
    resetn = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
    end
    checks++;
    if (dreq_valid !== 1'b0) begin
      failures++; $display("FAIL reset_dreq_valid got=%b exp=0", dreq_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    checks++;
    if (dut_rec() !== '0) begin
      failures++; $display("FAIL reset_out_fields got=%h exp=0", dut_rec());
    end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_alu();
    rec_v_t e;
    drive_op(64'h100, 64'h1234, 64'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd5);
    exp_q.push_back(mk_exp(64'h100, 64'h1234, 64'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL alu_latency got=%b exp=1", out_valid);
    end
    checks++;
    if (dreq_valid !== 1'b0) begin
      failures++; $display("FAIL alu_no_dreq got=%b exp=0", dreq_valid);
    end
    e = exp_q.pop_front();
    checks++;
    if (dut_rec() !== e) begin
      failures++; $display("FAIL alu_record got=%h exp=%h", dut_rec(), e);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL alu_pulse got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_load_d();
    rec_v_t e;
    int p0;
    bit bad;
    p0 = out_pulses;
    bad = 1'b0;
    drive_op(64'h200, 64'h8000_1000, 64'h0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 5'd10);
    exp_q.push_back(mk_exp(64'h200, 64'h8000_1000, 64'hDEAD_BEEF_CAFE_F00D, 5'd10,
                           1'b1, 1'b0, 1'b1, 2'd3, 1'b0));
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (dreq_valid !== 1'b1 || dreq_addr !== 64'h8000_1000 || in_ready !== 1'b0) bad = 1'b1;
      step();
    end
    checks++;
    if ({dreq_valid, dreq_write, dreq_strobe, dreq_addr} !== {1'b1, 1'b0, 8'h00, 64'h8000_1000}) begin
      failures++;
      $display("FAIL load_req got=%h exp=%h", {dreq_valid, dreq_write, dreq_strobe, dreq_addr},
               {1'b1, 1'b0, 8'h00, 64'h8000_1000});
    end
    dreq_ready = 1'b1;
    step();
    dreq_ready = 1'b0;
    if (dreq_valid !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
    step();
    if (in_ready !== 1'b0 || out_valid !== 1'b0) bad = 1'b1;
    dresp_valid = 1'b1;
    dresp_data = 64'hDEAD_BEEF_CAFE_F00D;
    step();
    dresp_valid = 1'b0;
    checks++;
    if (bad !== 1'b0) begin
      failures++; $display("FAIL load_wait_stable got=%b exp=0", bad);
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL load_out_valid got=%b exp=1", out_valid);
    end
    e = exp_q.pop_front();
    checks++;
    if (dut_rec() !== e) begin
      failures++; $display("FAIL load_record got=%h exp=%h", dut_rec(), e);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL load_ready_back got=%b exp=1", in_ready);
    end
    step();
    checks++;
    if (out_pulses - p0 !== 1) begin
      failures++; $display("FAIL load_pulse_count got=%0d exp=1", out_pulses - p0);
    end
  endtask

  task automatic test_store_lanes();
    logic [1:0]  sz   [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [63:0] addr [4] = '{64'h8000_0003, 64'h8000_0006, 64'h8000_0004, 64'h8000_0008};
    logic [63:0] wd   [4] = '{64'hFFFF_FFFF_FFFF_FFAB, 64'hFFFF_FFFF_FFFF_1234,
                              64'hFFFF_FFFF_1122_3344, 64'h0102_0304_0506_0708};
    logic [7:0]  estb [4] = '{8'h08, 8'hC0, 8'hF0, 8'hFF};
    logic [63:0] ewd  [4] = '{64'hABAB_ABAB_ABAB_ABAB, 64'h1234_1234_1234_1234,
                              64'h1122_3344_1122_3344, 64'h0102_0304_0506_0708};
    rec_v_t e;
    int p0;
    for (int i = 0; i < 4; i++) begin
      p0 = out_pulses;
      drive_op(64'h300 + 64'(i), addr[i], wd[i], 1'b0, 1'b1, sz[i], 1'b0, 1'b0, 5'd0);
      exp_q.push_back(mk_exp(64'h300 + 64'(i), addr[i], 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, sz[i], 1'b0));
      step();
      in_valid = 1'b0;
      dreq_ready = 1'b1;
      checks++;
      if ({dreq_valid, dreq_write, dreq_strobe, dreq_addr, dreq_wdata} !==
          {1'b1, 1'b1, estb[i], {addr[i][63:3], 3'b000}, ewd[i]}) begin
        failures++;
        $display("FAIL store_req_%0d got=%h exp=%h", i,
                 {dreq_valid, dreq_write, dreq_strobe, dreq_addr, dreq_wdata},
                 {1'b1, 1'b1, estb[i], {addr[i][63:3], 3'b000}, ewd[i]});
      end
      step();
      dreq_ready = 1'b0;
      dresp_valid = 1'b1;
      dresp_data = 64'h5555_5555_5555_5555;
      step();
      dresp_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || dut_rec() !== e) begin
        failures++;
        $display("FAIL store_record_%0d got=%b/%h exp=1/%h", i, out_valid, dut_rec(), e);
      end
      step();
      checks++;
      if (out_pulses - p0 !== 1) begin
        failures++; $display("FAIL store_pulse_count_%0d got=%0d exp=1", i, out_pulses - p0);
      end
    end
  endtask

  task automatic test_misalign();
    logic [1:0]  sz   [3] = '{2'd2, 2'd1, 2'd3};
    logic [63:0] addr [3] = '{64'h8000_0002, 64'h8000_0001, 64'h8000_0004};
    rec_v_t e;
    for (int i = 0; i < 3; i++) begin
      drive_op(64'h400, addr[i], 64'h0, 1'b1, 1'b0, sz[i], 1'b1, 1'b1, 5'd7);
      exp_q.push_back(mk_exp(64'h400, addr[i], 64'h0, 5'd7, 1'b0, 1'b1, 1'b1, sz[i], 1'b1));
      step();
      in_valid = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || dut_rec() !== e) begin
        failures++;
        $display("FAIL misalign_record_%0d got=%b/%h exp=1/%h", i, out_valid, dut_rec(), e);
      end
      checks++;
      if (dreq_valid !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL misalign_no_bus_%0d got=%b%b exp=01", i, dreq_valid, in_ready);
      end
    end
    step();
  endtask

  task automatic test_flush_idle_req();
    int p0;
    p0 = out_pulses;
    drive_op(64'h500, 64'h42, 64'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd3);
    flush = 1'b1;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_idle got=%b exp=0", out_valid);
    end
    drive_op(64'h504, 64'h8000_0010, 64'h0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 5'd4);
    step();
    in_valid = 1'b0;
    dreq_ready = 1'b1;
    flush = 1'b1;
    #1;
    checks++;
    if (dreq_valid !== 1'b0) begin
      failures++; $display("FAIL flush_req_gate got=%b exp=0", dreq_valid);
    end
    step();
    flush = 1'b0;
    dreq_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || dreq_valid !== 1'b0) begin
      failures++; $display("FAIL flush_req_idle got=%b%b exp=10", in_ready, dreq_valid);
    end
    dresp_valid = 1'b1;
    dresp_data = 64'h1;
    step();
    dresp_valid = 1'b0;
    step();
    checks++;
    if (out_pulses - p0 !== 0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_idle_req_quiet got=%0d/%b exp=0/1", out_pulses - p0, in_ready);
    end
  endtask

  task automatic test_flush_wait();
    int p0;
    p0 = out_pulses;
    drive_op(64'h600, 64'h8000_0020, 64'h0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 5'd8);
    step();
    in_valid = 1'b0;
    dreq_ready = 1'b1;
    step();
    dreq_ready = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL drain_busy got=%b exp=0", in_ready);
    end
    dresp_valid = 1'b1;
    dresp_data = 64'h77;
    step();
    dresp_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL drain_done got=%b%b exp=10", in_ready, out_valid);
    end
    drive_op(64'h610, 64'h8000_0028, 64'h0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 5'd9);
    step();
    in_valid = 1'b0;
    dreq_ready = 1'b1;
    step();
    dreq_ready = 1'b0;
    flush = 1'b1;
    dresp_valid = 1'b1;
    step();
    flush = 1'b0;
    dresp_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++; $display("FAIL flush_with_resp got=%b%b exp=10", in_ready, out_valid);
    end
    step();
    checks++;
    if (out_pulses - p0 !== 0) begin
      failures++; $display("FAIL flush_wait_quiet got=%0d exp=0", out_pulses - p0);
    end
  endtask

  task automatic test_reset_mid();
    rec_v_t e;
    int n;
    drive_op(64'h700, 64'h8000_0040, 64'h0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 5'd11);
    step();
    in_valid = 1'b0;
    checks++;
    if (dreq_valid !== 1'b1) begin
      failures++; $display("FAIL mid_req_up got=%b exp=1", dreq_valid);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (dreq_valid !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_reset_async got=%b%b%b exp=001", dreq_valid, out_valid, in_ready);
    end
    step();
    resetn = 1'b1;
    drive_op(64'h710, 64'h8000_0048, 64'h0, 1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 5'd12);
    exp_q.push_back(mk_exp(64'h710, 64'h8000_0048, 64'h0123_4567_89AB_CDEF, 5'd12,
                           1'b1, 1'b0, 1'b1, 2'd3, 1'b1));
    step();
    in_valid = 1'b0;
    dreq_ready = 1'b1;
    step();
    dreq_ready = 1'b0;
    dresp_valid = 1'b1;
    dresp_data = 64'h0123_4567_89AB_CDEF;
    step();
    dresp_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL mid_after_timeout got=%b exp=1", out_valid);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (dut_rec() !== e) begin
        failures++; $display("FAIL mid_after_record got=%h exp=%h", dut_rec(), e);
      end
    end
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_d();
    test_store_lanes();
    test_misalign();
    test_flush_idle_req();
    test_flush_wait();
    test_reset_mid();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
